// File: rtl/pulse_frame_buffer_if.sv
// Symbol-input and frame-output handshake bundle for pulse_frame_buffer.
interface pulse_frame_buffer_if #(
  parameter int SLOT_W = 4,
  parameter int DEPTH  = 16
) ();
  logic                    sym_valid;
  logic [SLOT_W-1:0]       sym_in;
  logic                    abort;
  logic                    frame_valid;
  logic                    frame_ready;
  logic [SLOT_W*DEPTH-1:0] frame;

  modport master (
    output sym_valid, sym_in, abort, frame_ready,
    input  frame_valid, frame
  );

  modport slave (
    input  sym_valid, sym_in, abort, frame_ready,
    output frame_valid, frame
  );
endinterface

// File: rtl/pulse_frame_buffer.sv
// Assembles DEPTH pulse symbols into a frame and double-buffers it behind a valid/ready handshake.
// Optional partial-frame timeout is enabled by defining PULSE_FRAME_TIMEOUT_EN.
module pulse_frame_buffer #(
  parameter int SLOT_W         = 4,
  parameter int DEPTH          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  pulse_frame_buffer_if.slave        bus,
  output logic [$clog2(DEPTH)-1:0]   fill_level,
  output logic                       overflow,
  input  logic                       ovf_clr,
  output logic [7:0]                 drop_cnt,
  output logic                       frame_timeout
);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int FRAME_W = SLOT_W * DEPTH;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [SLOT_W-1:0]  slots [DEPTH];
  logic [IDX_W-1:0]   wr_idx;
  logic [FRAME_W-1:0] frame_q;
  logic               frame_valid_q;
  logic [FRAME_W-1:0] assembled;
  logic [IDX_W-1:0]   wr_sel;
  logic               last_slot;
  logic               complete;
  logic               out_free;
  logic               drop;
  logic               timeout_hit;

  assign last_slot = (wr_idx == IDX_W'(DEPTH - 1));
  // abort with a symbol starts a new frame, so it never completes the old one
  assign complete  = bus.sym_valid && !bus.abort && last_slot;
  assign out_free  = !frame_valid_q || bus.frame_ready;
  assign drop      = complete && !out_free;
  assign wr_sel    = bus.abort ? '0 : wr_idx;

  always_comb begin
    assembled = '0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      assembled[i*SLOT_W +: SLOT_W] = slots[i];
    end
    assembled[(DEPTH-1)*SLOT_W +: SLOT_W] = bus.sym_in;
  end

`ifdef PULSE_FRAME_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] idle_cnt;
  logic             idle;
  logic             timeout_q;

  assign idle        = (wr_idx != '0) && !bus.sym_valid && !bus.abort;
  assign timeout_hit = idle && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_cnt  <= (idle && !timeout_hit) ? idle_cnt + CNT_W'(1) : '0;
      timeout_q <= timeout_hit;
    end
  end

  assign frame_timeout = timeout_q;
`else
  logic unused_timeout;
  assign unused_timeout = |32'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
  assign frame_timeout  = 1'b0;
`endif

  // symbol capture and write pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_idx <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        slots[i] <= '0;
      end
    end else begin
      if (bus.sym_valid) begin
        slots[wr_sel] <= bus.sym_in;
      end
      if (bus.abort) begin
        wr_idx <= bus.sym_valid ? IDX_W'(1) : '0;
      end else if (bus.sym_valid) begin
        wr_idx <= last_slot ? '0 : wr_idx + IDX_W'(1);
      end else if (timeout_hit) begin
        wr_idx <= '0;
      end
    end
  end

  // output register, handshake and drop accounting
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      overflow      <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      if (complete && out_free) begin
        frame_q       <= assembled;
        frame_valid_q <= 1'b1;
      end else if (frame_valid_q && bus.frame_ready) begin
        frame_valid_q <= 1'b0;
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
      if (drop || timeout_hit) begin
        drop_cnt <= sat_inc(drop_cnt);
      end
    end
  end

  assign bus.frame       = frame_q;
  assign bus.frame_valid = frame_valid_q;
  assign fill_level      = wr_idx;

endmodule

// File: tb/tb_pulse_frame_buffer.sv
// Directed bench for pulse_frame_buffer: a table-driven first frame plus hand-written corner sequences.
module tb_pulse_frame_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pulse_frame_buffer_if #(.SLOT_W(4), .DEPTH(16)) bus0 ();
  pulse_frame_buffer_if #(.SLOT_W(2), .DEPTH(4))  bus1 ();

  logic [3:0] fill0;
  logic       ovf0, clr0, to0;
  logic [7:0] drop0;
  logic [1:0] fill1;
  logic       ovf1, clr1, to1;
  logic [7:0] drop1;

  pulse_frame_buffer #(.SLOT_W(4), .DEPTH(16), .TIMEOUT_CYCLES(8)) u0 (
    .clk(clk), .rst(rst), .bus(bus0), .fill_level(fill0), .overflow(ovf0),
    .ovf_clr(clr0), .drop_cnt(drop0), .frame_timeout(to0)
  );

  pulse_frame_buffer #(.SLOT_W(2), .DEPTH(4), .TIMEOUT_CYCLES(8)) u1 (
    .clk(clk), .rst(rst), .bus(bus1), .fill_level(fill1), .overflow(ovf1),
    .ovf_clr(clr1), .drop_cnt(drop1), .frame_timeout(to1)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // drive one cycle on u0 (called at a falling edge, returns at the next one)
  task automatic cyc(input logic sv, input logic [3:0] sym, input logic ab,
                     input logic rdy, input logic clr);
    bus0.sym_valid   = sv;
    bus0.sym_in      = sym;
    bus0.abort       = ab;
    bus0.frame_ready = rdy;
    clr0             = clr;
    @(negedge clk);
  endtask

  task automatic send_n(input int n, input logic [3:0] sym, input logic rdy);
    for (int i = 0; i < n; i++) cyc(1'b1, sym, 1'b0, rdy, 1'b0);
  endtask

  typedef struct {
    logic        sv;
    logic [3:0]  sym;
    logic        rdy;
    logic        exp_valid;
    logic [63:0] exp_frame;
    logic [3:0]  exp_fill;
  } vec_t;

  vec_t vecs[17];

  initial begin
    for (int k = 0; k < 16; k++) begin
      vecs[k].sv        = 1'b1;
      vecs[k].sym       = 4'(k);
      vecs[k].rdy       = 1'b1;
      vecs[k].exp_valid = (k == 15);
      vecs[k].exp_frame = (k == 15) ? 64'hFEDCBA9876543210 : 64'h0;
      vecs[k].exp_fill  = 4'((k + 1) % 16);
    end
    vecs[16] = '{1'b0, 4'h0, 1'b1, 1'b0, 64'hFEDCBA9876543210, 4'h0};

    bus0.sym_valid = 0; bus0.sym_in = 0; bus0.abort = 0; bus0.frame_ready = 0; clr0 = 0;
    bus1.sym_valid = 0; bus1.sym_in = 0; bus1.abort = 0; bus1.frame_ready = 1; clr1 = 0;

    repeat (3) @(negedge clk);
    chk("reset_valid", {63'b0, bus0.frame_valid}, 64'h0);
    chk("reset_fill", {60'b0, fill0}, 64'h0);
    chk("reset_drop", {56'b0, drop0}, 64'h0);
    rst = 1'b1;
    @(negedge clk);

    // frame of 0..F with downstream always ready
    for (int k = 0; k < 17; k++) begin
      cyc(vecs[k].sv, vecs[k].sym, 1'b0, vecs[k].rdy, 1'b0);
      chk($sformatf("t1_valid[%0d]", k), {63'b0, bus0.frame_valid}, {63'b0, vecs[k].exp_valid});
      chk($sformatf("t1_fill[%0d]", k), {60'b0, fill0}, {60'b0, vecs[k].exp_fill});
      if (vecs[k].exp_valid || k == 16)
        chk($sformatf("t1_frame[%0d]", k), bus0.frame, vecs[k].exp_frame);
    end

    // overflow: second frame dropped while downstream stalls; set beats clear
    send_n(16, 4'h3, 1'b0);
    chk("t2_valid", {63'b0, bus0.frame_valid}, 64'h1);
    send_n(15, 4'h5, 1'b0);
    cyc(1'b1, 4'h5, 1'b0, 1'b0, 1'b1);
    chk("t2_frame_kept", bus0.frame, 64'h3333333333333333);
    chk("t2_ovf_set_wins", {63'b0, ovf0}, 64'h1);
    chk("t2_drop", {56'b0, drop0}, 64'h1);
    cyc(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("t2_ovf_clr", {63'b0, ovf0}, 64'h0);
    chk("t2_drop_kept", {56'b0, drop0}, 64'h1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("t2_drained", {63'b0, bus0.frame_valid}, 64'h0);

    // drain and reload on the same cycle
    send_n(16, 4'h7, 1'b0);
    chk("t3_first", bus0.frame, 64'h7777777777777777);
    send_n(15, 4'h9, 1'b0);
    chk("t3_stable", bus0.frame, 64'h7777777777777777);
    cyc(1'b1, 4'h9, 1'b0, 1'b1, 1'b0);
    chk("t3_valid", {63'b0, bus0.frame_valid}, 64'h1);
    chk("t3_frame", bus0.frame, 64'h9999999999999999);
    chk("t3_no_drop", {56'b0, drop0}, 64'h1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // abort with a symbol realigns the frame start
    send_n(7, 4'h2, 1'b0);
    cyc(1'b1, 4'hA, 1'b1, 1'b0, 1'b0);
    chk("t4_fill_abort", {60'b0, fill0}, 64'h1);
    send_n(15, 4'h1, 1'b0);
    chk("t4_frame", bus0.frame, 64'h111111111111111A);
    chk("t4_valid", {63'b0, bus0.frame_valid}, 64'h1);
    chk("t4_no_drop", {56'b0, drop0}, 64'h1);
    send_n(3, 4'h4, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("t4_abort_fill", {60'b0, fill0}, 64'h0);
    chk("t4_abort_keeps_valid", {63'b0, bus0.frame_valid}, 64'h1);
    chk("t4_abort_keeps_frame", bus0.frame, 64'h111111111111111A);
    cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);

    // partial frame left idle
    send_n(5, 4'h6, 1'b1);
`ifdef PULSE_FRAME_TIMEOUT_EN
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("t5_timeout[%0d]", i), {63'b0, to0}, {63'b0, (i == 8)});
    end
    chk("t5_fill", {60'b0, fill0}, 64'h0);
    chk("t5_drop", {56'b0, drop0}, 64'h2);
    cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("t5_pulse_end", {63'b0, to0}, 64'h0);
`else
    repeat (12) cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("t5_no_timeout", {63'b0, to0}, 64'h0);
    chk("t5_fill_kept", {60'b0, fill0}, 64'h5);
    chk("t5_drop", {56'b0, drop0}, 64'h1);
    cyc(1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
`endif

    // narrow instance: SLOT_W=2, DEPTH=4
    for (int i = 0; i < 4; i++) begin
      bus1.sym_valid = 1'b1;
      bus1.sym_in    = 2'((i + 1) % 4);
      @(negedge clk);
    end
    bus1.sym_valid = 1'b0;
    chk("t6_valid", {63'b0, bus1.frame_valid}, 64'h1);
    chk("t6_frame", {56'b0, bus1.frame}, 64'h39);

    // drop counter saturation
    for (int f = 0; f < 260; f++) send_n(16, 4'hC, 1'b0);
    chk("t7_drop_sat", {56'b0, drop0}, 64'hFF);
    chk("t7_ovf", {63'b0, ovf0}, 64'h1);

    // asynchronous reset mid-frame
    send_n(5, 4'hE, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("t8_valid", {63'b0, bus0.frame_valid}, 64'h0);
    chk("t8_frame", bus0.frame, 64'h0);
    chk("t8_fill", {60'b0, fill0}, 64'h0);
    chk("t8_ovf", {63'b0, ovf0}, 64'h0);
    chk("t8_drop", {56'b0, drop0}, 64'h0);
    chk("t8_timeout", {63'b0, to0}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    send_n(16, 4'hB, 1'b0);
    chk("t8_after_reset", bus0.frame, 64'hBBBBBBBBBBBBBBBB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
